// File: rtl/branch_target_buffer_pkg.sv
// Shared types for the direct-mapped branch target buffer: PC width, BTB geometry and sweep state.
package branch_target_buffer_pkg;

    localparam int ADDR_WIDTH = 32;
    typedef logic [ADDR_WIDTH-1:0] PC;

    localparam int BTB_ENTRY_NUM   = 64;
    localparam int BTB_INDEX_WIDTH = $clog2(BTB_ENTRY_NUM);
    localparam int BTB_TAG_WIDTH   = ADDR_WIDTH - BTB_INDEX_WIDTH - 2;

    typedef logic [BTB_INDEX_WIDTH-1:0] BtbIndex;
    typedef logic [BTB_TAG_WIDTH-1:0]   BtbTag;

    typedef struct packed {
        logic  valid;
        BtbTag tag;
        PC     target;
    } BtbEntry;

    typedef enum logic {
        BTB_INIT,
        BTB_READY
    } BtbState;

endpackage

// File: rtl/branch_target_buffer_sweep_ctrl.sv
// Clear-sweep controller: walks every BTB index once after reset or invalidate, then reports ready.
//  state     | meaning
//  BTB_INIT  | clearing valid[sw_idx], one entry per cycle
//  BTB_READY | table usable for lookup and update
module btb_sweep_ctrl
    import branch_target_buffer_pkg::*;
#(
    parameter int ENTRY_NUM = BTB_ENTRY_NUM,
    localparam int INDEX_W  = $clog2(ENTRY_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               invalidate_all,
    output logic               clr_en,
    output logic [INDEX_W-1:0] clr_idx,
    output logic               ready
);

    localparam logic [INDEX_W-1:0] IDX_ONE  = INDEX_W'(1);
    localparam logic [INDEX_W-1:0] IDX_LAST = INDEX_W'(ENTRY_NUM - 1);

    BtbState            state_q, state_d;
    logic [INDEX_W-1:0] sw_idx_q, sw_idx_d;
    logic               ready_q, ready_d;

    always_comb begin
        state_d  = state_q;
        sw_idx_d = sw_idx_q;
        ready_d  = ready_q;
        // Invalidate restarts the walk from index 0 regardless of progress.
        if (invalidate_all) begin
            state_d  = BTB_INIT;
            sw_idx_d = '0;
            ready_d  = 1'b0;
        end else if (state_q == BTB_INIT) begin
            sw_idx_d = sw_idx_q + IDX_ONE;
            if (sw_idx_q == IDX_LAST) begin
                state_d  = BTB_READY;
                sw_idx_d = '0;
                ready_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BTB_INIT;
            sw_idx_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sw_idx_q <= sw_idx_d;
            ready_q  <= ready_d;
        end
    end

    assign clr_en  = (state_q == BTB_INIT);
    assign clr_idx = sw_idx_q;
    assign ready   = ready_q;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational lookup on the fetch PC, synchronous update from branch resolution.
// Optional BTB_HYSTERESIS_EN adds a per-entry confidence bit so one stray alias cannot evict a hot entry.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int ENTRY_NUM = BTB_ENTRY_NUM
) (
    input  logic clk,
    input  logic rst,
    input  PC    lookupPc,
    output logic btbHit,
    output PC    btbPredictedPc,
    input  logic updateEn,
    input  PC    updatePc,
    input  PC    updateTarget,
    input  logic updateTaken,
    input  logic invalidateAll,
    output logic ready
);

    localparam int INDEX_W = $clog2(ENTRY_NUM);
    localparam int TAG_W   = ADDR_WIDTH - INDEX_W - 2;

    logic [INDEX_W-1:0] lk_idx, up_idx, clr_idx;
    logic [TAG_W-1:0]   lk_tag, up_tag;
    logic               clr_en, upd_ok, write_en;
    logic               unused_pc_lsbs;

    logic [ENTRY_NUM-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_mem [ENTRY_NUM];
    PC                    tgt_mem [ENTRY_NUM];

    assign lk_idx = lookupPc[INDEX_W+1:2];
    assign lk_tag = lookupPc[ADDR_WIDTH-1:INDEX_W+2];
    assign up_idx = updatePc[INDEX_W+1:2];
    assign up_tag = updatePc[ADDR_WIDTH-1:INDEX_W+2];
    assign unused_pc_lsbs = ^{lookupPc[1:0], updatePc[1:0]};

    btb_sweep_ctrl #(.ENTRY_NUM(ENTRY_NUM)) u_sweep (
        .clk            (clk),
        .rst            (rst),
        .invalidate_all (invalidateAll),
        .clr_en         (clr_en),
        .clr_idx        (clr_idx),
        .ready          (ready)
    );

    // Updates only land in READY; a concurrent invalidate discards them.
    assign upd_ok = ready & updateEn & ~invalidateAll;

`ifdef BTB_HYSTERESIS_EN
    logic [ENTRY_NUM-1:0] conf_q, conf_d;
    logic                 up_hit;

    assign up_hit   = valid_q[up_idx] & (tag_mem[up_idx] == up_tag);
    assign write_en = upd_ok & updateTaken & (~valid_q[up_idx] | ~conf_q[up_idx] | up_hit);

    always_comb begin
        conf_d = conf_q;
        if (clr_en) conf_d[clr_idx] = 1'b0;
        if (upd_ok) begin
            if (updateTaken)  conf_d[up_idx] = write_en;
            else if (up_hit)  conf_d[up_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        conf_q <= conf_d;
    end
`else
    assign write_en = upd_ok & updateTaken;
`endif

    always_comb begin
        valid_d = valid_q;
        if (clr_en)   valid_d[clr_idx] = 1'b0;
        if (write_en) valid_d[up_idx]  = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            tag_mem[up_idx] <= up_tag;
            tgt_mem[up_idx] <= updateTarget;
        end
    end

    // Read path sees pre-update contents when update and lookup share an index.
    assign btbHit         = ready & valid_q[lk_idx] & (tag_mem[lk_idx] == lk_tag);
    assign btbPredictedPc = btbHit ? tgt_mem[lk_idx] : '0;

endmodule
